// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - WIDTH-bit add/subtract split into STAGES registered ripple segments
// Optional feature macro: PIPE_ADD_OVF_EN (registered two's-complement overflow flag on ovf).
module pipelined_ripple_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  // The whole pipe moves together; a held result freezes every stage, bubbles included.
  logic w_adv;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added when entering this stage, and sum bits known after it.
    localparam int WIN = WIDTH - k * SEG;
    localparam int LO  = (k + 1) * SEG;

    logic [WIN-1:0] w_a_in;
    logic [WIN-1:0] w_b_in;
    logic           w_c_in;
    logic           w_v_in;
    logic [SEG:0]   w_seg;
    logic [LO-1:0]  w_sum_nxt;

    logic           r_valid;
    logic           r_c;
    logic [LO-1:0]  r_sum;

    if (k == 0) begin : g_src
      // Subtract folds into an add: invert B here and force the carry-in to 1.
      assign w_a_in    = a;
      assign w_b_in    = sub ? ~b : b;
      assign w_c_in    = sub | cin;
      assign w_v_in    = in_valid;
      assign w_sum_nxt = w_seg[SEG-1:0];
    end else begin : g_src
      assign w_a_in    = g_stage[k-1].g_ops.r_a;
      assign w_b_in    = g_stage[k-1].g_ops.r_b;
      assign w_c_in    = g_stage[k-1].r_c;
      assign w_v_in    = g_stage[k-1].r_valid;
      assign w_sum_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
    end

    assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]} + (SEG+1)'(w_c_in);

    // Register this segment's partial sum, its carry-out and the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_c     <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_v_in;
        r_c     <= w_seg[SEG];
        r_sum   <= w_sum_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [WIN-SEG-1:0] r_a;
      logic [WIN-SEG-1:0] r_b;

      // Carry forward only the operand segments later stages have yet to consume.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_in[WIN-1:SEG];
          r_b <= w_b_in[WIN-1:SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;

`ifdef PIPE_ADD_OVF_EN
  logic w_cmsb;
  logic r_cmsb;

  // Carry into the MSB recovered from the MSB's own inputs and sum bit.
  assign w_cmsb = g_stage[STAGES-1].w_a_in[SEG-1] ^ g_stage[STAGES-1].w_b_in[SEG-1]
                ^ g_stage[STAGES-1].w_seg[SEG-1];

  // Keep the MSB carry-in alongside the last stage so it stalls with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmsb <= 1'b0;
    end else if (w_adv) begin
      r_cmsb <= w_cmsb;
    end
  end

  assign ovf = out_valid & (r_cmsb ^ cout);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - randomized scoreboard bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

  localparam int W = 32;
  localparam int S = 4;
`ifdef PIPE_ADD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           t;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   tick = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Plain arithmetic reference: result, carry and sign-rule overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W:0]   r;
    logic [W-1:0] be;
    exp_t         e;
    be  = sb ? ~y : y;
    r   = {1'b0, x} + {1'b0, be} + (W+1)'(sb ? 1'b1 : ci);
    e.t = 0;
    e.s = r[W-1:0];
    e.c = r[W];
    e.o = OVF_ON & (x[W-1] == be[W-1]) & (r[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].t + S == tick);
  endfunction

  // One clock: compare outputs against the model, drive new inputs, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb, input logic ordy);
    exp_t e;
    bit   ev;
    bit   adv;
    @(negedge clk);
    chk("out_valid", out_valid, exp_valid());
    chk("in_ready", in_ready, !exp_valid() || out_ready);
    if (exp_valid()) begin
      chk("sum", sum, q[0].s);
      chk("cout", cout, q[0].c);
      chk("ovf", ovf, q[0].o);
    end else begin
      chk("ovf_idle", ovf, 0);
    end
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    @(posedge clk);
    ev  = exp_valid();
    adv = !ev || out_ready;
    if (ev && out_ready) void'(q.pop_front());
    if (adv) begin
      if (in_valid) begin
        e   = model(a, b, cin, sub);
        e.t = tick;
        q.push_back(e);
      end
      tick++;
    end
  endtask

  task automatic bubble(input logic ordy);
    step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic rnd_op(input logic ordy);
    step(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), ordy);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      bubble(1'b1);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int n;
    drain();
    step(1'b1, x, y, ci, sb, 1'b1);
    n = 1;
    #1;
    while (!out_valid && n < 20) begin
      bubble(1'b1);
      n++;
      #1;
    end
    chk({nm, "_lat"}, n, S);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    logic [W-1:0] hold;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    // Hand-computed values pin the reference model itself.
    e = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_wrap", {e.c, e.s}, 33'h1_0000_0000);
    e = model(32'h5, 32'h7, 1'b1, 1'b1);
    chk("model_sub_neg", {e.c, e.s}, 33'h0_FFFF_FFFE);
    e = model(32'h7, 32'h5, 1'b1, 1'b1);
    chk("model_sub_pos", {e.c, e.s}, 33'h1_0000_0002);
    e = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_ovf", e.o, OVF_ON);

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    directed("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("sub_5_7", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_7_5", 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0);
    directed("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
    directed("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, OVF_ON);
    directed("no_ovf", 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0);

    // Back-to-back stream at full rate.
    drain();
    for (int i = 0; i < 16; i++) rnd_op(1'b1);
    drain();

    // Backpressure with a full pipe: outputs and in_ready must hold.
    for (int i = 0; i < 6; i++) rnd_op(1'b1);
    #1;
    hold = sum;
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      rnd_op(1'b0);
      #1;
      chk("bp_hold_sum", sum, hold);
      chk("bp_in_ready", in_ready, 0);
    end
    drain();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) rnd_op(1'b1);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    q.delete();
    tick = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) bubble(1'b1);

    // Random valid/ready mix.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
